// File: rtl/decode_field_stage.sv
// Instruction-field decode stage: splits a fetched instruction into fields and holds them
// in a one-entry valid/ready pipeline register. A dependent instruction is held off for one
// cycle when the instruction leaving the stage is a load that writes a register it reads.
module decode_field_stage #(
  parameter int INST_SIZE = 16,
  parameter int OP_W      = 3,
  parameter int REG_W     = 3,
  parameter int FUNCT_W   = 4,
  parameter int IMM_W     = 7,
  parameter int DATA_W    = 16,
  parameter logic [OP_W-1:0] LOAD_OP = 3'b100,
  parameter logic [2**OP_W-1:0] ZEXT_MASK = 8'b0100_0000,
  parameter int CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [INST_SIZE-1:0]      in_instr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OP_W-1:0]           opcode,
  output logic [REG_W-1:0]          rs,
  output logic [REG_W-1:0]          rt,
  output logic [REG_W-1:0]          rd,
  output logic [FUNCT_W-1:0]        funct,
  output logic [DATA_W-1:0]         imm_ext,
  output logic [INST_SIZE-OP_W-1:0] jtarget,
  output logic                      is_load,
  output logic [CNT_W-1:0]          hazard_cnt
);

  localparam int RS_HI = INST_SIZE - OP_W - 1;
  localparam int RT_HI = RS_HI - REG_W;
  localparam int RD_HI = RT_HI - REG_W;

  logic [OP_W-1:0]    in_op;
  logic [REG_W-1:0]   in_rs;
  logic [REG_W-1:0]   in_rt;
  logic [REG_W-1:0]   in_rd;
  logic [FUNCT_W-1:0] in_funct;
  logic [IMM_W-1:0]   in_imm;
  logic [DATA_W-1:0]  in_imm_ext;
  logic               in_zext;
  logic               hazard;
  logic               accept;

  assign in_op    = in_instr[INST_SIZE-1 -: OP_W];
  assign in_rs    = in_instr[RS_HI -: REG_W];
  assign in_rt    = in_instr[RT_HI -: REG_W];
  assign in_rd    = in_instr[RD_HI -: REG_W];
  assign in_funct = in_instr[FUNCT_W-1:0];
  assign in_imm   = in_instr[IMM_W-1:0];
  assign in_zext  = ZEXT_MASK[in_op];

  // Fill the upper bits first, then overlay the raw immediate; works for DATA_W == IMM_W too.
  always_comb begin
    if (in_zext || !in_imm[IMM_W-1]) in_imm_ext = '0;
    else                             in_imm_ext = '1;
    in_imm_ext[IMM_W-1:0] = in_imm;
  end

  assign hazard = in_valid && out_valid && is_load && (rt != '0) &&
                  ((in_rs == rt) || (in_rt == rt));
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      opcode     <= '0;
      rs         <= '0;
      rt         <= '0;
      rd         <= '0;
      funct      <= '0;
      imm_ext    <= '0;
      jtarget    <= '0;
      is_load    <= 1'b0;
      hazard_cnt <= '0;
    end else begin
      if (hazard && (hazard_cnt != '1))
        hazard_cnt <= hazard_cnt + 1'b1;

      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        opcode    <= in_op;
        rs        <= in_rs;
        rt        <= in_rt;
        rd        <= in_rd;
        funct     <= in_funct;
        imm_ext   <= in_imm_ext;
        jtarget   <= in_instr[INST_SIZE-OP_W-1:0];
        is_load   <= (in_op == LOAD_OP);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_field_stage.sv
// Self-checking bench for decode_field_stage: directed scenarios plus randomized traffic,
// all compared every cycle against a transaction-level reference model.
module tb_decode_field_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  opcode;
  logic [2:0]  rs;
  logic [2:0]  rt;
  logic [2:0]  rd;
  logic [3:0]  funct;
  logic [15:0] imm_ext;
  logic [12:0] jtarget;
  logic        is_load;
  logic [7:0]  hazard_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: the held instruction word, its valid flag and the hazard count.
  bit          m_valid;
  int unsigned m_instr;
  int unsigned m_cnt;

  decode_field_stage dut (
    .clk(clk), .rst_n(rst_n), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm_ext(imm_ext),
    .jtarget(jtarget), .is_load(is_load), .hazard_cnt(hazard_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned f_op(input int unsigned w);  return (w / 8192) % 8; endfunction
  function automatic int unsigned f_rs(input int unsigned w);  return (w / 1024) % 8; endfunction
  function automatic int unsigned f_rt(input int unsigned w);  return (w / 128) % 8;  endfunction
  function automatic int unsigned f_rd(input int unsigned w);  return (w / 16) % 8;   endfunction
  function automatic int unsigned f_imm(input int unsigned w);
    int unsigned raw = w % 128;
    if (f_op(w) == 6 || raw < 64) return raw;
    return raw + 16'hFF80;
  endfunction

  // One clock cycle: drive inputs, compare every output to the model, advance the model.
  task automatic step(input bit v, input logic [15:0] ins, input bit ordy, input bit fl, input bit rn);
    bit hz, rdy;
    int unsigned w;
    in_valid = v; in_instr = ins; out_ready = ordy; flush = fl; rst_n = rn;
    w = ins;
    #2;
    hz  = v && m_valid && f_op(m_instr) == 4 && f_rt(m_instr) != 0 &&
          (f_rs(w) == f_rt(m_instr) || f_rt(w) == f_rt(m_instr));
    rdy = (!m_valid || ordy) && !hz;
    chk("out_valid", out_valid, m_valid);
    chk("in_ready", in_ready, rdy);
    chk("opcode", opcode, f_op(m_instr));
    chk("rs", rs, f_rs(m_instr));
    chk("rt", rt, f_rt(m_instr));
    chk("rd", rd, f_rd(m_instr));
    chk("funct", funct, m_instr % 16);
    chk("imm_ext", imm_ext, f_imm(m_instr));
    chk("jtarget", jtarget, m_instr % 8192);
    chk("is_load", is_load, f_op(m_instr) == 4);
    chk("hazard_cnt", hazard_cnt, m_cnt);
    if (!rn) begin
      m_valid = 0; m_instr = 0; m_cnt = 0;
    end else begin
      if (hz && m_cnt < 255) m_cnt++;
      if (fl)                  m_valid = 0;
      else if (v && rdy)       begin m_valid = 1; m_instr = w; end
      else if (m_valid && ordy) m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] r;
    m_valid = 0; m_instr = 0; m_cnt = 0;
    rst_n = 0; in_valid = 0; in_instr = '0; out_ready = 1; flush = 0;
    @(posedge clk); #1;
    step(0, 16'h0000, 1, 0, 0);
    step(0, 16'h0000, 1, 0, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);

    // Field split and extension
    step(1, 16'h09C0, 1, 0, 1);
    chk("split_rs", rs, 2);
    chk("split_rt", rt, 3);
    chk("split_rd", rd, 4);
    chk("split_jt", jtarget, 13'h09C0);
    step(1, 16'h20FF, 1, 0, 1);
    chk("sext", imm_ext, 16'hFFFF);
    step(1, 16'hC0FF, 1, 0, 1);
    chk("zext", imm_ext, 16'h007F);
    step(0, 16'h0000, 1, 0, 1);

    // Load-use bubble: load, then dependent presented while the load fires
    step(1, 16'h8505, 1, 0, 1);
    chk("lu_is_load", is_load, 1);
    step(1, 16'h09C0, 1, 0, 1);
    chk("lu_bubble", out_valid, 0);
    chk("lu_cnt", hazard_cnt, 1);
    step(1, 16'h09C0, 1, 0, 1);
    chk("lu_emit", {out_valid, rs, rt}, {1'b1, 3'd2, 3'd3});

    // Load to r0: no bubble
    step(1, 16'h8405, 1, 0, 1);
    step(1, 16'h0040, 1, 0, 1);
    chk("r0_nobubble", out_valid, 1);
    chk("r0_cnt", hazard_cnt, 1);

    // Backpressure then release
    step(1, 16'h1234, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 16'h2345, 0, 0, 1);
    step(1, 16'h2345, 1, 0, 1);
    chk("bp_accept", jtarget, 13'h0345);

    // Flush with held and incoming instruction
    step(1, 16'h3456, 1, 1, 1);
    chk("flush_ov", out_valid, 0);
    chk("flush_nocap", jtarget, 13'h0345);

    // Reset mid-stream
    step(1, 16'h4567, 1, 0, 1);
    step(1, 16'h5678, 1, 0, 0);
    chk("midrst_ov", out_valid, 0);
    chk("midrst_jt", jtarget, 0);

    // Randomized traffic with frequent loads and a small register set
    for (int i = 0; i < 3000; i++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 3) == 0) r[15:13] = 3'b100;
      r[12:7] = 6'($urandom_range(0, 63) & 6'b011011);
      step($urandom_range(0, 3) != 0, r, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 99) != 0);
    end

    // Saturation: held load stalled by backpressure, dependent presented for 300 cycles
    step(0, 16'h0000, 1, 0, 0);
    step(1, 16'h8505, 1, 0, 1);
    for (int i = 0; i < 300; i++) step(1, 16'h09C0, 0, 0, 1);
    chk("sat_cnt", hazard_cnt, 8'hFF);
    step(1, 16'h09C0, 1, 1, 1);
    chk("sat_noclr", hazard_cnt, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_field_stage.md
# decode_field_stage

Parametrised instruction-field decode stage with a registered output, a valid/ready handshake, stall/flush support, immediate extension and load-use hazard bubbling. It sits between the fetch unit and the register file/control unit of the MIPS pipeline. It splits each accepted instruction into opcode/rs/rt/rd/funct/imm/jump-target fields and holds them in a one-entry pipeline register. It refuses an instruction that reads the destination of a load leaving the stage in the same cycle.

## Interface
- INST_SIZE, 16, instruction width
- OP_W, 3, opcode width (MSBs)
- REG_W, 3, register-specifier width for rs, rt, rd
- FUNCT_W, 4, funct width (LSBs)
- IMM_W, 7, immediate width (LSBs)
- DATA_W, 16, extended-immediate width; must be ≥ IMM_W
- LOAD_OP, 3'b100, opcode of the load instruction (writes rt)
- ZEXT_MASK, 8'b0100_0000, bit k set means opcode k zero-extends its immediate; all other opcodes sign-extend; width 2**OP_W
- CNT_W, 8, hazard counter width
- Constraint: OP_W + 3*REG_W + FUNCT_W == INST_SIZE.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- in_instr  in  INST_SIZE  fetched instruction
- in_valid  in  1  in_instr valid
- in_ready  out  1  stage accepts in_instr this cycle
- flush  in  1  discard held instruction
- out_valid  out  1  decoded fields valid
- out_ready  in  1  downstream accepts fields
- opcode  out  OP_W  instr[INST_SIZE-1 -: OP_W]
- rs  out  REG_W  next REG_W bits below opcode
- rt  out  REG_W  next REG_W bits below rs
- rd  out  REG_W  next REG_W bits below rt
- funct  out  FUNCT_W  instr[FUNCT_W-1:0]
- imm_ext  out  DATA_W  instr[IMM_W-1:0], sign- or zero-extended
- jtarget  out  INST_SIZE-OP_W  instr[INST_SIZE-OP_W-1:0]
- is_load  out  1  held opcode == LOAD_OP
- hazard_cnt  out  CNT_W  count of cycles in which a hazard blocked acceptance

## Operation
- Field extraction and extension are combinational on in_instr. Results are captured into the output register on accept.
- Accept happens when in_valid && in_ready && !flush.
- in_ready = (!out_valid || out_ready) && !hazard.
- hazard = in_valid && out_valid && is_load && rt != 0 && (in_rs == rt || in_rt == rt). Here rt is the held load's destination.
- Register update priority:
  - Reset clears everything.
  - flush clears out_valid. No capture, even if in_valid is high.
  - Accept loads all fields and sets out_valid = 1.
  - Output fire without accept clears out_valid.
  - Otherwise the register holds its value.
- When out_valid && !out_ready, every output stays stable.
- Fields are not cleared when out_valid drops. Consumers must qualify them with out_valid.
- hazard_cnt increments once per cycle with hazard = 1. It saturates at all-ones and does not wrap. flush does not clear it; only reset does.
- Register 0 never causes a hazard.
- Non-load held instructions never cause a hazard.

## Timing
- Reset: out_valid = 0, every field output = 0, is_load = 0, hazard_cnt = 0. in_ready is 1 during and after reset while in_valid = 0.
- Latency: 1 cycle. An instruction accepted at edge t is on the outputs with out_valid = 1 after edge t.
- Throughput: 1 instruction per cycle when out_ready stays high and no hazard occurs.
- Load-use case:
  - The load fires at cycle t; a dependent instruction is presented at cycle t.
  - in_ready = 0 at t, so the dependent is rejected.
  - At t+1 the register is empty and the dependent is accepted.
  - out_valid is 0 for one cycle between load and dependent (exactly one bubble).
- Same cycle fire and accept of an independent instruction: no bubble.
- flush with in_valid high: the instruction is not accepted, in_ready is ignored, and out_valid = 0 next cycle.
- rst_n low mid-stream: next cycle is the full reset state; any in-flight instruction is lost.

## Test plan
- Field split:
  - Stimulus: in_instr = 16'h09C0, in_valid = 1, out_ready = 1.
  - Required response next cycle: opcode = 0, rs = 2, rt = 3, rd = 4, funct = 0, jtarget = 13'h09C0, out_valid = 1, is_load = 0.
- Extension:
  - 16'h20FF → imm_ext = 16'hFFFF.
  - 16'hC0FF (opcode 6, in ZEXT_MASK) → imm_ext = 16'h007F.
- Load-use bubble:
  - Stimulus: 16'h8505 (load, rt = 2), then 16'h09C0 (rs = 2) presented while the load fires.
  - Required response: in_ready = 0 for 1 cycle, one out_valid = 0 bubble, hazard_cnt = 1, and 09C0 emitted next.
  - Repeat with rt = 0 in the load: no bubble and hazard_cnt unchanged.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 3 cycles with in_valid = 1.
  - Required response: in_ready = 0 and outputs stable for all 3 cycles. When out_ready rises, the next instruction is accepted the same cycle.
- Flush and reset:
  - flush with out_valid = 1 and in_valid = 1: out_valid = 0 next cycle, nothing captured.
  - rst_n = 0 for 1 cycle mid-stream: all outputs 0 and hazard_cnt = 0.
- Saturation: force 300 hazard cycles with CNT_W = 8 → hazard_cnt = 8'hFF, with no wrap.
